// File: rtl/input_selector_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | input_selector_ctrl                                                       |
// | Round-robin sequencer that walks input_selector over every nibble of the  |
// | granted source and streams them out on a valid/ready handshake.           |
// | Option macro: INPUT_SELECTOR_CTRL_MSB_FIRST_EN (most significant first).  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module input_selector_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       reqMain,
  input  logic       reqRegs,
  input  logic [3:0] r,
  input  logic       outReady,
  output logic       wBusy,
  output logic       wSelecOrigin,
  output logic [3:0] wSelecMain,
  output logic [5:0] wSelecRegs,
  output logic [3:0] outData,
  output logic       outValid,
  output logic       outLast,
  output logic       ackMain,
  output logic       ackRegs
);

  localparam int         MAIN_NIBBLES = 16;
  localparam int         REGS_NIBBLES = 64;
  localparam logic [5:0] MAIN_LAST    = 6'(MAIN_NIBBLES - 1);
  localparam logic [5:0] REGS_LAST    = 6'(REGS_NIBBLES - 1);
`ifdef INPUT_SELECTOR_CTRL_MSB_FIRST_EN
  localparam logic [3:0] MAIN_START   = MAIN_LAST[3:0];
  localparam logic [5:0] REGS_START   = REGS_LAST;
  localparam logic [5:0] STEP         = 6'h3f;  // -1 modulo the index width
`else
  localparam logic [3:0] MAIN_START   = 4'd0;
  localparam logic [5:0] REGS_START   = 6'd0;
  localparam logic [5:0] STEP         = 6'd1;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       last_regs_q, last_regs_d;
  logic [5:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       origin_q, origin_d;
  logic [3:0] sel_main_q, sel_main_d;
  logic [5:0] sel_regs_q, sel_regs_d;
  logic [3:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic       ack_main_q, ack_main_d;
  logic       ack_regs_q, ack_regs_d;
  logic       grant_regs;

  always_comb begin
    state_d     = state_q;
    last_regs_d = last_regs_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    origin_d    = origin_q;
    sel_main_d  = sel_main_q;
    sel_regs_d  = sel_regs_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    ack_main_d  = 1'b0;
    ack_regs_d  = 1'b0;
    grant_regs  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // On a tie the source that did not win last time takes the grant.
        grant_regs = reqRegs && (!reqMain || !last_regs_q);
        if (reqMain || reqRegs) begin
          state_d    = S_FETCH;
          busy_d     = 1'b1;
          origin_d   = grant_regs;
          sel_main_d = grant_regs ? 4'd0 : MAIN_START;
          sel_regs_d = grant_regs ? REGS_START : 6'd0;
          cnt_d      = grant_regs ? REGS_LAST : MAIN_LAST;
        end
      end

      S_FETCH: begin
        state_d = S_SEND;
        data_d  = r;
        valid_d = 1'b1;
        last_d  = (cnt_q == 6'd0);
        if (origin_q) sel_regs_d = sel_regs_q + STEP;
        else          sel_main_d = sel_main_q + STEP[3:0];
      end

      S_SEND: begin
        if (outReady) begin
          if (cnt_q == 6'd0) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            origin_d    = 1'b0;
            sel_main_d  = 4'd0;
            sel_regs_d  = 6'd0;
            valid_d     = 1'b0;
            last_d      = 1'b0;
            ack_main_d  = !origin_q;
            ack_regs_d  = origin_q;
            last_regs_d = origin_q;
          end else begin
            data_d = r;
            cnt_d  = cnt_q - 6'd1;
            last_d = (cnt_q == 6'd1);
            if (origin_q) sel_regs_d = sel_regs_q + STEP;
            else          sel_main_d = sel_main_q + STEP[3:0];
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_regs_q <= 1'b1;
      cnt_q       <= 6'd0;
      busy_q      <= 1'b0;
      origin_q    <= 1'b0;
      sel_main_q  <= 4'd0;
      sel_regs_q  <= 6'd0;
      data_q      <= 4'd0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      ack_main_q  <= 1'b0;
      ack_regs_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_regs_q <= last_regs_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      origin_q    <= origin_d;
      sel_main_q  <= sel_main_d;
      sel_regs_q  <= sel_regs_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      ack_main_q  <= ack_main_d;
      ack_regs_q  <= ack_regs_d;
    end
  end

  assign wBusy        = busy_q;
  assign wSelecOrigin = origin_q;
  assign wSelecMain   = sel_main_q;
  assign wSelecRegs   = sel_regs_q;
  assign outData      = data_q;
  assign outValid     = valid_q;
  assign outLast      = last_q;
  assign ackMain      = ack_main_q;
  assign ackRegs      = ack_regs_q;

endmodule
`default_nettype wire

// File: tb/tb_input_selector_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_input_selector_ctrl                                                    |
// | Bench for input_selector_ctrl with a behavioural nibble selector.         |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_input_selector_ctrl;

`ifdef INPUT_SELECTOR_CTRL_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, reqMain, reqRegs, outReady;
  logic [3:0]   r;
  logic         wBusy, wSelecOrigin, outValid, outLast, ackMain, ackRegs;
  logic [3:0]   wSelecMain, outData;
  logic [5:0]   wSelecRegs;
  logic [63:0]  wData = 64'h0123456789abcdef;
  logic [255:0] wDataRegs;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  // Stand-in for input_selector: combinational nibble mux.
  always_comb r = wSelecOrigin ? wDataRegs[{wSelecRegs, 2'b00} +: 4]
                               : wData[{wSelecMain, 2'b00} +: 4];

  input_selector_ctrl dut (
    .clk(clk), .reset(reset), .reqMain(reqMain), .reqRegs(reqRegs), .r(r),
    .outReady(outReady), .wBusy(wBusy), .wSelecOrigin(wSelecOrigin),
    .wSelecMain(wSelecMain), .wSelecRegs(wSelecRegs), .outData(outData),
    .outValid(outValid), .outLast(outLast), .ackMain(ackMain), .ackRegs(ackRegs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int start_idx(input bit src);
    int n = src ? 64 : 16;
    return MSB_FIRST ? n - 1 : 0;
  endfunction

  // Beat b of a transfer is nibble b counted from the chosen end of the word.
  function automatic logic [3:0] exp_nib(input bit src, input int b);
    int n   = src ? 64 : 16;
    int idx = MSB_FIRST ? n - 1 - b : b;
    return src ? wDataRegs[idx*4 +: 4] : wData[idx*4 +: 4];
  endfunction

  task automatic xfer(input bit src, input int pct, input bit pulse);
    int n = src ? 64 : 16;
    int beats = 0, busy = 0, stalls = 0, cyc = 0;
    bit done = 1'b0, stalled = 1'b0, rdy;
    logic [3:0] pd = 4'd0;
    logic pl = 1'b0;
    while (wBusy !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("grant_busy", wBusy, 1);
    chk("grant_origin", wSelecOrigin, src);
    chk("fetch_valid", outValid, 0);
    chk("ack_clear", {ackMain, ackRegs}, 0);
    chk("start_idx", src ? wSelecRegs : {2'b00, wSelecMain}, start_idx(src));
    chk("other_idx", src ? {2'b00, wSelecMain} : wSelecRegs, 0);
    if (pulse) begin
      reqMain = 1'b0;
      reqRegs = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 2000) begin
      if (wBusy === 1'b1) busy++;
      if (outValid === 1'b1) begin
        if (stalled) begin
          chk("hold_data", outData, pd);
          chk("hold_last", outLast, pl);
        end
        chk("xfer_origin", wSelecOrigin, src);
        rdy = ($urandom_range(99) < pct);
        outReady = rdy;
        if (rdy) begin
          chk("beat_data", outData, exp_nib(src, beats));
          chk("beat_last", outLast, beats == n - 1);
          beats++;
          done = (beats == n);
        end else begin
          stalls++;
        end
        stalled = !rdy;
        pd = outData;
        pl = outLast;
      end
      @(negedge clk);
      cyc++;
    end
    chk("xfer_timeout", done, 1);
    chk("ack_main", ackMain, !src);
    chk("ack_regs", ackRegs, src);
    chk("end_valid", outValid, 0);
    chk("end_busy", wBusy, 0);
    chk("end_idx", {wSelecOrigin, wSelecMain, wSelecRegs}, 0);
    chk("busy_cycles", busy, n + 1 + stalls);
  endtask

  initial begin
    reset = 1'b1; reqMain = 1'b0; reqRegs = 1'b0; outReady = 1'b0;
    for (int i = 0; i < 8; i++) wDataRegs[i*32 +: 32] = $urandom;
    repeat (2) @(negedge clk);
    chk("rst_outs", {wBusy, wSelecOrigin, wSelecMain, wSelecRegs, outData,
                     outValid, outLast, ackMain, ackRegs}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", wBusy, 0);

    // Single main request at full rate, then single regs request.
    reqMain = 1'b1;
    xfer(1'b0, 100, 1'b1);
    @(negedge clk);
    chk("ack_pulse_main", {ackMain, ackRegs}, 0);
    reqRegs = 1'b1;
    xfer(1'b1, 100, 1'b1);
    @(negedge clk);
    chk("ack_pulse_regs", {ackMain, ackRegs}, 0);

    // Both held: grants alternate, main first since regs went last.
    reqMain = 1'b1; reqRegs = 1'b1;
    xfer(1'b0, 100, 1'b0);
    xfer(1'b1, 100, 1'b0);
    xfer(1'b0, 100, 1'b0);
    reqMain = 1'b0; reqRegs = 1'b0;
    @(negedge clk);
    chk("idle_after_rr", wBusy, 0);

    // Backpressure with fresh random register data.
    for (int i = 0; i < 8; i++) wDataRegs[i*32 +: 32] = $urandom;
    reqMain = 1'b1;
    xfer(1'b0, 50, 1'b1);
    reqRegs = 1'b1;
    xfer(1'b1, 60, 1'b1);

    // Reset in the middle of a main transfer.
    @(negedge clk);
    reqMain = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    reqMain = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_valid", outValid, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst", {wBusy, wSelecOrigin, wSelecMain, wSelecRegs, outValid,
                      outLast, outData}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_ack_after_rst", {ackMain, ackRegs, wBusy}, 0);
    end
    reqMain = 1'b1;
    xfer(1'b0, 100, 1'b1);

    // Random mix of sources and ready rates.
    for (int i = 0; i < 4; i++) begin
      bit s;
      s = 1'($urandom_range(1));
      @(negedge clk);
      if (s) reqRegs = 1'b1;
      else   reqMain = 1'b1;
      xfer(s, int'($urandom_range(30, 100)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
